// File: rtl/adff_release_seq.sv
// -----------------------------------------------------------------------------
// adff_release_seq
//
// Async-reset register bank with a synchronised, sequenced reset release.
// ARST clears everything immediately and without a clock. Its release is
// re-timed into the CLK domain through a SYNC_STAGES-deep shift chain, after
// which Q is held at ARST_VALUE for HOLD_CYCLES further edges before the bank
// starts accepting D.
//
// Parameters:
//   WIDTH        - data width of D/Q
//   CLK_POLARITY - 1: active on posedge CLK, 0: active on negedge CLK
//   ARST_VALUE   - value loaded into Q during reset and held until RUN
//   SYNC_STAGES  - release synchroniser depth (2..8)
//   HOLD_CYCLES  - edges spent in HOLD after synchronised release (0..255)
//
// Ports:
//   CLK      in   clock, active edge selected by CLK_POLARITY
//   ARST     in   asynchronous active-high reset
//   EN       in   load enable, honoured only in RUN
//   D        in   next data
//   Q        out  registered data
//   RST_DONE out  registered, high exactly while the sequencer is in RUN
// -----------------------------------------------------------------------------
module adff_release_seq #(
    parameter int unsigned      WIDTH        = 1,
    parameter bit               CLK_POLARITY = 1'b1,
    parameter logic [WIDTH-1:0] ARST_VALUE   = '0,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter int unsigned      HOLD_CYCLES  = 4
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RST_DONE
);

    // Last counter value spent in HOLD; only meaningful when HOLD_CYCLES > 0.
    localparam bit         HoldEn   = (HOLD_CYCLES > 0);
    localparam logic [7:0] HoldLast = HoldEn ? 8'(HOLD_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StHold  = 2'd1,
        StRun   = 2'd2
    } state_e;

    // Single clock net for all state; inverting it selects the negedge variant
    // so no logic ever sits on the inactive edge.
    logic clk_act;
    assign clk_act = CLK_POLARITY ? CLK : ~CLK;

    // -------------------------------------------------------------------------
    // Release synchroniser: async-cleared chain that fills with ones once ARST
    // is low. The last stage is the re-timed release.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rel_s;

    always_ff @(posedge clk_act or posedge ARST) begin
        if (ARST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rel_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Release sequencer with registered outputs.
    // -------------------------------------------------------------------------
    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             done_q;

    always_ff @(posedge clk_act or posedge ARST) begin
        if (ARST) begin
            state_q <= StReset;
            cnt_q   <= 8'd0;
            q_q     <= ARST_VALUE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StReset: begin
                    q_q <= ARST_VALUE;
                    if (rel_s) begin
                        if (HoldEn) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StRun;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    q_q   <= ARST_VALUE;
                    // Exit compares against HOLD_CYCLES-1, so the final
                    // increment never exceeds 255 and cannot wrap.
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == HoldLast) begin
                        state_q <= StRun;
                        done_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // The entering edge was taken in HOLD/RESET, so the first
                    // capture lands one edge after RST_DONE rises.
                    if (EN) begin
                        q_q <= D;
                    end
                end
                default: begin
                    state_q <= StReset;
                    cnt_q   <= 8'd0;
                    q_q     <= ARST_VALUE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign RST_DONE = done_q;

endmodule

// File: tb/tb_adff_release_seq.sv
`timescale 1ns/1ps
module tb_adff_release_seq;

    // Configurations under test.
    localparam int SA = 2, HA = 4;     // defaults
    localparam int SB = 3, HB = 0;     // no hold window
    localparam int SC = 2, HC = 255;   // negedge, max hold, ARST_VALUE=FF
    localparam int ThrA = SA + 1 + HA; // edges from release to RST_DONE
    localparam int ThrB = SB + 1 + HB;
    localparam int ThrC = SC + 1 + HC;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] qa, qb, qc;
    logic       da, db, dc;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    adff_release_seq #(
        .WIDTH(8), .CLK_POLARITY(1'b1), .ARST_VALUE(8'h00),
        .SYNC_STAGES(SA), .HOLD_CYCLES(HA)
    ) dut_a (
        .CLK(clk), .ARST(arst), .EN(en), .D(d), .Q(qa), .RST_DONE(da)
    );

    adff_release_seq #(
        .WIDTH(8), .CLK_POLARITY(1'b1), .ARST_VALUE(8'h00),
        .SYNC_STAGES(SB), .HOLD_CYCLES(HB)
    ) dut_b (
        .CLK(clk), .ARST(arst), .EN(en), .D(d), .Q(qb), .RST_DONE(db)
    );

    adff_release_seq #(
        .WIDTH(8), .CLK_POLARITY(1'b0), .ARST_VALUE(8'hFF),
        .SYNC_STAGES(SC), .HOLD_CYCLES(HC)
    ) dut_c (
        .CLK(clk), .ARST(arst), .EN(en), .D(d), .Q(qc), .RST_DONE(dc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: count active edges since ARST last fell; the bank is
    // live once that count reaches SYNC_STAGES+1+HOLD_CYCLES.
    int         since_a, since_b, since_c;
    logic [7:0] mq_a, mq_b, mq_c;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            since_a <= 0;
            mq_a    <= 8'h00;
        end else begin
            if (since_a >= ThrA && en) mq_a <= d;
            if (since_a < 100000) since_a <= since_a + 1;
        end
    end

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            since_b <= 0;
            mq_b    <= 8'h00;
        end else begin
            if (since_b >= ThrB && en) mq_b <= d;
            if (since_b < 100000) since_b <= since_b + 1;
        end
    end

    always @(negedge clk or posedge arst) begin
        if (arst) begin
            since_c <= 0;
            mq_c    <= 8'hFF;
        end else begin
            if (since_c >= ThrC && en) mq_c <= d;
            if (since_c < 100000) since_c <= since_c + 1;
        end
    end

    // Continuous model comparison, each sampled on its inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a_q", qa, mq_a);
            check("model_a_done", da, since_a >= ThrA);
            check("model_b_q", qb, mq_b);
            check("model_b_done", db, since_b >= ThrB);
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            check("model_c_q", qc, mq_c);
            check("model_c_done", dc, since_c >= ThrC);
        end
    end

    typedef struct {
        logic       arst;
        logic       en;
        logic [7:0] d;
        logic [7:0] qa;
        logic       da;
        logic [7:0] qb;
        logic       db;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Release sequence for the default and no-hold instances, then EN gating.
        tbl[0]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0}; // edge 1
        tbl[2]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b1}; // b done edge 4
        tbl[5]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b1}; // b capture
        tbl[6]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b1}; // a done edge 7
        tbl[8]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 8'hA5, 1'b1}; // a capture
        tbl[9]  = '{1'b0, 1'b0, 8'h11, 8'hA5, 1'b1, 8'hA5, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h22, 8'hA5, 1'b1, 8'hA5, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h33, 8'hA5, 1'b1, 8'hA5, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 8'h44, 8'h44, 1'b1, 8'h44, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 8'h3C, 1'b1};

        // Reset state, no clock edge needed.
        #1 arst = 1'b1;
        #1;
        check("rst_a_q", qa, 8'h00);
        check("rst_a_done", da, 1'b0);
        check("rst_b_q", qb, 8'h00);
        check("rst_b_done", db, 1'b0);
        check("rst_c_q", qc, 8'hFF);
        check("rst_c_done", dc, 1'b0);
        chk_en = 1'b1;

        // Inputs change at posedge+3, outputs sampled at posedge+2.
        @(posedge clk);
        #3;
        for (int i = 0; i < 14; i++) begin
            arst = tbl[i].arst;
            en   = tbl[i].en;
            d    = tbl[i].d;
            @(posedge clk);
            #2;
            check($sformatf("tbl%0d_a_q", i), qa, tbl[i].qa);
            check($sformatf("tbl%0d_a_done", i), da, tbl[i].da);
            check($sformatf("tbl%0d_b_q", i), qb, tbl[i].qb);
            check($sformatf("tbl%0d_b_done", i), db, tbl[i].db);
            #1;
        end

        // 1 ns ARST pulse in RUN: immediate clear, then the full sequence again.
        en = 1'b1;
        d  = 8'h77;
        arst = 1'b1;
        #0.5;
        check("pulse_a_q", qa, 8'h00);
        check("pulse_a_done", da, 1'b0);
        check("pulse_b_q", qb, 8'h00);
        check("pulse_b_done", db, 1'b0);
        #0.5;
        arst = 1'b0;
        #1;
        check("pulse_after_a_q", qa, 8'h00);
        check("pulse_after_a_done", da, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("rel%0d_a_done", k), da, k >= 7);
            check($sformatf("rel%0d_a_q", k), qa, (k >= 8) ? 8'h77 : 8'h00);
            check($sformatf("rel%0d_b_done", k), db, k >= 4);
            check($sformatf("rel%0d_b_q", k), qb, (k >= 5) ? 8'h77 : 8'h00);
            #1;
        end

        // ARST low for a single edge: release must never complete.
        arst = 1'b1;
        @(posedge clk);
        #3;
        arst = 1'b0;
        @(posedge clk);
        #2;
        check("short_low_a_done", da, 1'b0);
        check("short_low_a_q", qa, 8'h00);
        #1;
        arst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            check("short_a_done", da, 1'b0);
            check("short_a_q", qa, 8'h00);
            check("short_b_done", db, 1'b0);
            check("short_b_q", qb, 8'h00);
            #1;
        end

        // Negedge instance with a 255-edge hold window.
        arst = 1'b0;
        en   = 1'b1;
        d    = 8'h5A;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            #2;
            check($sformatf("c_neg%0d_done", k), dc, k >= 258);
            check($sformatf("c_neg%0d_q", k), qc, (k >= 259) ? 8'h5A : 8'hFF);
            @(posedge clk);
            #1;
            check($sformatf("c_pos%0d_done", k), dc, k >= 258);
            check($sformatf("c_pos%0d_q", k), qc, (k >= 259) ? 8'h5A : 8'hFF);
        end
        #2;

        // Randomised segments separated by ARST events, plus rare glitches.
        for (int s = 0; s < 8; s++) begin
            int len;
            len = (s % 3 == 0) ? 300 : int'($urandom_range(120, 5));
            if ($urandom_range(1, 0) == 1) begin
                arst = 1'b1;
                #0.5;
                arst = 1'b0;
            end else begin
                arst = 1'b1;
                @(posedge clk);
                #3;
                arst = 1'b0;
            end
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(99, 0) == 0) begin
                    arst = 1'b1;
                    #0.5;
                    arst = 1'b0;
                end
                en = 1'($urandom);
                d  = 8'($urandom);
                @(posedge clk);
                #3;
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
